// File: rtl/wb_stage.sv
// Writeback stage: commits EX_WB bundles to a 32-entry register file, raises branch
// redirects and squashes wrong-path bundles. Optional same-cycle read bypass: WB_BYPASS_EN.
module wb_stage #(
  parameter int NREG         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [70:0] EX_WB,
  input  logic        ex_valid,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        flushing,
  output logic [31:0] retire_count,
  output logic [3:0]  dbg_state
);

  typedef enum logic { RUN = 1'b0, FLUSH = 1'b1 } state_e;

  state_e      state_q;
  logic [2:0]  flush_cnt_q;
  logic        pc_redirect_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] retire_count_q;
  logic [31:0] retire_count_d;
  logic [31:0] regs_q [NREG];

  logic [31:0] wb_data;
  logic [31:0] wb_target;
  logic [4:0]  wb_dest;
  logic        wb_branch;
  logic        wb_en;
  logic        accept;
  logic        do_write;
  logic        do_branch;

  assign wb_data   = EX_WB[31:0];
  assign wb_target = EX_WB[63:32];
  assign wb_dest   = EX_WB[68:64];
  assign wb_branch = EX_WB[69];
  assign wb_en     = EX_WB[70];

  // Only bundles seen in RUN are on the correct path; anything arriving in FLUSH is dropped.
  assign accept    = ex_valid && (state_q == RUN);
  assign do_write  = accept && wb_en && (wb_dest != 5'd0) && (int'(wb_dest) < NREG);
  assign do_branch = accept && wb_branch;

  assign retire_count_d = retire_count_q + {31'd0, accept};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      flush_cnt_q    <= 3'd0;
      pc_redirect_q  <= 1'b0;
      redirect_pc_q  <= 32'd0;
      retire_count_q <= 32'd0;
    end else begin
      pc_redirect_q  <= do_branch;
      retire_count_q <= retire_count_d;
      if (do_branch) redirect_pc_q <= wb_target;
      case (state_q)
        RUN: begin
          if (do_branch && (FLUSH_CYCLES != 0)) begin
            state_q     <= FLUSH;
            flush_cnt_q <= 3'(FLUSH_CYCLES);
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q - 3'd1;
          if (flush_cnt_q == 3'd1) state_q <= RUN;
        end
        default: begin
          state_q     <= RUN;
          flush_cnt_q <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 32'd0;
    end else if (do_write) begin
      regs_q[wb_dest] <= wb_data;
    end
  end

  // Register 0 and any address beyond NREG read as zero.
  always_comb begin
    rs_data = 32'd0;
    rt_data = 32'd0;
    if ((rs_addr != 5'd0) && (int'(rs_addr) < NREG)) rs_data = regs_q[rs_addr];
    if ((rt_addr != 5'd0) && (int'(rt_addr) < NREG)) rt_data = regs_q[rt_addr];
`ifdef WB_BYPASS_EN
    if (do_write && (wb_dest == rs_addr)) rs_data = wb_data;
    if (do_write && (wb_dest == rt_addr)) rt_data = wb_data;
`endif
  end

  assign pc_redirect  = pc_redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign flushing     = (state_q == FLUSH);
  assign retire_count = retire_count_q;
  assign dbg_state    = {(state_q == FLUSH), flush_cnt_q};

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized bench for wb_stage, checked against a commit-window model.
module tb_wb_stage;
  localparam int FLUSH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [70:0] EX_WB = '0;
  logic        ex_valid = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data, rt_data, redirect_pc, retire_count;
  logic        pc_redirect, flushing;
  logic [3:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Model: a bundle at edge e commits iff e > (edge of last accepted branch) + FLUSH.
  logic [31:0] mregs [32];
  logic [31:0] mcount;
  longint      edge_idx;
  longint      last_br;
  logic        exp_redir;
  logic [31:0] exp_rpc;

  wb_stage #(.NREG(32), .FLUSH_CYCLES(FLUSH)) dut (
    .clock(clock), .reset(reset), .EX_WB(EX_WB), .ex_valid(ex_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .flushing(flushing),
    .retire_count(retire_count), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcount    = 32'd0;
    last_br   = -1000;
    exp_redir = 1'b0;
    exp_rpc   = 32'd0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    ex_valid = 1'b0;
    reset    = 1'b1;
    model_reset();
    #1;
    chk({tag, "_flushing"}, {31'd0, flushing}, 32'd0);
    chk({tag, "_redirect"}, {31'd0, pc_redirect}, 32'd0);
    chk({tag, "_retire"}, retire_count, 32'd0);
    chk({tag, "_dbg"}, {28'd0, dbg_state}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic step(input logic v, input logic we, input logic br, input logic [4:0] dest,
                      input logic [31:0] data, input logic [31:0] pc,
                      input logic [4:0] ra, input logic [4:0] rb);
    logic acc, qual, in_win;
    logic [31:0] er, et;
    @(negedge clock);
    ex_valid = v;
    EX_WB    = {we, br, dest, pc, data};
    rs_addr  = ra;
    rt_addr  = rb;
    #1;
    acc  = v && ((edge_idx + 1) > (last_br + FLUSH));
    qual = acc && we && (dest != 5'd0);
    er = mregs[ra];
    et = mregs[rb];
`ifdef WB_BYPASS_EN
    if (qual && dest == ra) er = data;
    if (qual && dest == rb) et = data;
`endif
    chk("rs_data", rs_data, er);
    chk("rt_data", rt_data, et);
    @(posedge clock);
    edge_idx++;
    exp_redir = acc && br;
    if (acc) begin
      if (qual) mregs[dest] = data;
      mcount = mcount + 32'd1;
      if (br) begin
        last_br = edge_idx;
        exp_rpc = pc;
      end
    end
    #1;
    in_win = (edge_idx < last_br + FLUSH);
    chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, exp_redir});
    if (exp_redir) chk("redirect_pc", redirect_pc, exp_rpc);
    chk("flushing", {31'd0, flushing}, {31'd0, in_win});
    chk("dbg_state", {28'd0, dbg_state},
        in_win ? {28'd0, 1'b1, 3'(last_br + FLUSH - edge_idx)} : 32'd0);
    chk("retire_count", retire_count, mcount);
  endtask

  initial begin
    edge_idx = 0;
    model_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;

    // Reset state, including every read-port address.
    do_reset("reset");
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      chk("reset_rs", rs_data, 32'd0);
      chk("reset_rt", rt_data, 32'd0);
    end

    // Basic write, then the same bundle to reg 0.
    step(1, 1, 0, 5'd5, 32'h0000_1234, 32'h0, 5'd0, 5'd0);
    step(1, 1, 0, 5'd0, 32'h0000_1234, 32'h0, 5'd5, 5'd0);
    chk("reg5_value", mregs[5], 32'h0000_1234);
    step(0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);

    // Branch then three back-to-back writes to reg 7: only the last commits.
    step(1, 0, 1, 5'd0, 32'h0, 32'h0000_0040, 5'd7, 5'd5);
    step(1, 1, 0, 5'd7, 32'd1, 32'h0, 5'd7, 5'd5);
    step(1, 1, 0, 5'd7, 32'd2, 32'h0, 5'd7, 5'd5);
    step(1, 1, 0, 5'd7, 32'd3, 32'h0, 5'd7, 5'd5);
    step(0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0);
    chk("retire_after_branch", mcount, 32'd4);

    // Second branch inside the window is ignored.
    step(1, 0, 1, 5'd0, 32'h0, 32'h0000_0100, 5'd7, 5'd0);
    step(1, 0, 1, 5'd0, 32'h0, 32'h0000_0080, 5'd7, 5'd0);
    step(1, 1, 0, 5'd8, 32'h55, 32'h0, 5'd8, 5'd0);
    step(1, 1, 0, 5'd8, 32'h66, 32'h0, 5'd8, 5'd0);
    step(0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd0);

    // Same-cycle write and read of reg 9.
    step(1, 1, 0, 5'd9, 32'h1111_2222, 32'h0, 5'd0, 5'd0);
    step(1, 1, 0, 5'd9, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd9);
    step(0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)), $urandom(), $urandom(),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Reset in the middle of a flush window.
    step(1, 0, 1, 5'd0, 32'h0, 32'h0000_0200, 5'd0, 5'd0);
    do_reset("midflush");
    step(1, 1, 0, 5'd3, 32'hCAFE_0003, 32'h0, 5'd3, 5'd0);
    step(0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);

    // Retire counter wrap.
    @(negedge clock);
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    mcount = 32'hFFFF_FFFF;
    step(1, 1, 0, 5'd4, 32'h4444_4444, 32'h0, 5'd0, 5'd0);
    chk("wrap_zero", mcount, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the fetch/decode/execute pipeline. It consumes the 71-bit `EX_WB` bundle from the execute stage and commits results into a 32-entry register file, which feeds decode through two read ports. Bundles flagged as branches raise a one-cycle PC redirect and squash the wrong-path bundles that follow. A retire counter tracks committed instructions.

## Interface
Parameters:
- `NREG`, 32: register-file entries; address width is fixed at 5 bits.
- `FLUSH_CYCLES`, 2: number of cycles after a redirect during which incoming bundles are discarded. Legal range 0..7.

Ports:
- `clock`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `EX_WB`  in  71: bundle from execute. Fields:
  - [31:0] wbdata
  - [63:32] pc / branch target
  - [68:64] destination register
  - [69] branch flag
  - [70] writeback enable
- `ex_valid`  in  1: `EX_WB` holds a new bundle this cycle.
- `rs_addr`  in  5: read port A address (from decode).
- `rt_addr`  in  5: read port B address (from decode).
- `rs_data`  out  32: port A data; combinational from the register file.
- `rt_data`  out  32: port B data; combinational from the register file.
- `pc_redirect`  out  1: one-cycle pulse; fetch loads `redirect_pc`.
- `redirect_pc`  out  32: branch target; valid while `pc_redirect` is high.
- `flushing`  out  1: high while wrong-path bundles are being discarded.
- `retire_count`  out  32: number of committed bundles.

## Operation
- FSM states: RUN and FLUSH, with a 3-bit `flush_cnt`.
- **RUN, accepting a bundle:** when `ex_valid` is high the bundle is accepted. An accepted bundle:
  - writes `regs[EX_WB[68:64]] <= EX_WB[31:0]` if `EX_WB[70]` = 1 and the destination is not 0;
  - increments `retire_count` by 1, wrapping modulo 2^32.
- **RUN, branch bundle:** an accepted bundle with `EX_WB[69]` = 1 additionally:
  - sets `pc_redirect` to 1 and `redirect_pc <= EX_WB[63:32]` for the next cycle only;
  - loads `flush_cnt <= FLUSH_CYCLES` and enters FLUSH, or stays in RUN if `FLUSH_CYCLES` = 0.
  - The branch bundle's own write and retire still happen.
- **FLUSH:** each cycle decrements `flush_cnt`; the FSM returns to RUN when it reaches 1→0.
  - Bundles arriving in FLUSH (valid or not) cause no write, no retire and no redirect. A branch arriving in FLUSH is ignored.
  - `flushing` = (state == FLUSH).
- **Register 0:** always reads 0 and is never written.
- **Read ports:** return the current contents of the register file.
- **Simultaneous events:** a write and a read of the same register in the same cycle return the old value unless `WB_BYPASS_EN` is defined (see Configuration).
- **Reset mid-operation:** FSM goes to RUN with `flush_cnt` = 0 immediately. A pending redirect is dropped, and the pending write is lost.

## Timing
- **Write latency:** bundle sampled at edge N; register updated at edge N; new value visible on read ports after edge N.
- **Redirect timing:** `pc_redirect` is high from edge N to edge N+1 for a branch sampled at edge N.
- **Flush window:** bundles sampled at edges N+1 .. N+`FLUSH_CYCLES` are discarded.
- **Throughput:** one bundle per cycle; no backpressure toward execute.
- **Reset values:**
  - `regs[*]` = 0
  - `pc_redirect` = 0
  - `redirect_pc` = 0
  - `flushing` = 0
  - `retire_count` = 0
  - read-port data = 0

## Configuration
- `WB_BYPASS_EN` defined: if a qualifying write (accepted, `EX_WB[70]` = 1, destination not 0) targets `rs_addr` or `rt_addr` in the same cycle, that port returns `EX_WB[31:0]` combinationally.
- `WB_BYPASS_EN` undefined: ports always return the stored value, so decode sees the new value one cycle later.

## Test plan
- **Reset state:** assert reset, read regs 0..31 → all 0; `retire_count` = 0; `pc_redirect` = 0.
- **Basic write:** bundle wbdata=0x0000_1234, dest=5, [70]=1, valid → after edge `rs_addr`=5 reads 0x1234; `retire_count` = 1. Same bundle with dest=0 → reg0 stays 0, `retire_count` = 2.
- **Branch and flush:** branch bundle [69]=1, pc=0x0000_0040, followed by 3 back-to-back writes to reg 7 with values 1, 2, 3 (`FLUSH_CYCLES`=2) → `pc_redirect` high for exactly 1 cycle with `redirect_pc`=0x40; `flushing` high for 2 cycles; reg7 = 3; `retire_count` +2.
- **Branch during FLUSH:** second branch to 0x80 inside the window → no second pulse; window length unchanged.
- **Bypass:** write 0xDEAD_BEEF to reg 9 while `rt_addr`=9 → same cycle `rt_data`=0xDEADBEEF with `WB_BYPASS_EN` defined, old value without it.
- **Reset mid-flush and counter wrap:** assert reset mid-flush → `flushing` drops immediately; next bundle commits. Force `retire_count` to 0xFFFF_FFFF, commit one bundle → 0.
